// File: rtl/priority_decoder.sv
// priority_decoder
//
// Decodes a 5-bit index into a 32-bit vector and queues the result in a small
// circular output buffer that has a valid/ready handshake on both sides.
//
// Handshake rule (both sides): a word moves on a rising clk edge where the
// producer's valid and the consumer's ready are both 1. While valid is 1 and
// ready is 0, the producer holds its data and valid stable.
//
// Parameters:
//   DEPTH  output buffer depth in entries (power of two, 2..16)
//   CNT_W  width of the delivered-word counter
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset (release synchronised by parent)
//   in_valid     upstream index valid
//   in_ready     block can accept an index (registered, equals !full)
//   I0           index to decode, 0..31
//   in_zero      decode to all-zeros, I0 ignored
//   thermo_mode  thermometer decode select (only with PRIODEC_THERMO_EN)
//   O0           decoded word at buffer head (32'h0 when empty)
//   out_valid    O0 holds a valid word
//   out_ready    downstream accepts O0
//   dec_count    words delivered downstream, saturating
//
// Build option: define PRIODEC_THERMO_EN to add the thermo_mode port. When
// thermo_mode is 1 at accept, bits [I0:0] are set instead of the single bit.
// in_zero always wins over thermo_mode.

module priority_decoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       I0,
    input  logic             in_zero,
`ifdef PRIODEC_THERMO_EN
    input  logic             thermo_mode,
`endif
    output logic [31:0]      O0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] dec_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          ready_q;
    logic          push;
    logic          pop;
    logic [31:0]   dec_word;

    assign in_ready  = ready_q;
    assign out_valid = (count != '0);
    assign O0        = out_valid ? mem[rd_ptr] : 32'h0;

    // push uses the registered ready, so a pop on a full buffer cannot let a
    // push through on the same edge.
    assign push = in_valid && ready_q;
    assign pop  = out_valid && out_ready;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        dec_word = 32'h0;
        if (!in_zero) begin
`ifdef PRIODEC_THERMO_EN
            if (thermo_mode) begin
                for (int i = 0; i < 32; i++) begin
                    dec_word[i] = (5'(i) <= I0);
                end
            end else begin
                dec_word[I0] = 1'b1;
            end
`else
            dec_word[I0] = 1'b1;
`endif
        end
    end

    // Storage needs no reset: O0 is masked to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dec_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ready_q   <= 1'b0;
            dec_count <= '0;
        end else begin
            count <= count_nxt;
            // ready_q is 0 during reset and comes up on the first edge after
            // release, so no word can be accepted on that edge.
            ready_q <= (count_nxt != FULL_LVL);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                if (dec_count != '1) begin
                    dec_count <= dec_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
